fir_mc: RTL and testbench

//  Parametrised, time-multiplexed, multi-channel FIR filter. Successor to the fixed 10-tap/16-bit fir.

---
 rtl/fir_pkg.sv | 26 ++
 rtl/fir_delay_line.sv | 46 ++++
 rtl/fir_mc.sv | 132 +++++++++++++
 tb/tb_fir_mc.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and helpers for the multi-channel FIR: FSM state encoding,
// accumulator sizing and the round/saturate narrowing helper.
package fir_pkg;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  function automatic int acc_w(input int data_w, input int coef_w, input int num_taps);
    return data_w + coef_w + $clog2(num_taps);
  endfunction

  // Round-half-up on the dropped bits, then clamp to the signed out_w range.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                   input int shift, input int out_w);
    logic signed [63:0] r;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    r = acc;
    if (shift > 0) r = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
    max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (out_w - 1));
    if (r > max_v) r = max_v;
    else if (r < min_v) r = min_v;
    return r;
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Per-channel circular sample history. The read port returns x_c[n-k] for the
// selected channel, where n is the most recently written sample.
module fir_delay_line #(
  parameter int NUM_TAPS = 10,
  parameter int DATA_W   = 16,
  parameter int NUM_CH   = 2,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int K_W     = $clog2(NUM_TAPS)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     we,
  input  logic [CH_W-1:0]          wr_ch,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic [CH_W-1:0]          rd_ch,
  input  logic [K_W-1:0]           rd_k,
  output logic signed [DATA_W-1:0] rd_data
);

  logic signed [DATA_W-1:0] mem [NUM_CH][NUM_TAPS];
  logic [K_W-1:0]           wr_ptr [NUM_CH];
  logic [K_W:0]             idx_sum;
  logic [K_W-1:0]           rd_idx;

  // The pointer sits one past the newest sample, so tap k lives at ptr-1-k.
  always_comb begin
    idx_sum = {1'b0, wr_ptr[rd_ch]} + (K_W+1)'(NUM_TAPS - 1) - {1'b0, rd_k};
    rd_idx  = idx_sum[K_W-1:0];
    if (idx_sum >= (K_W+1)'(NUM_TAPS)) rd_idx = K_W'(idx_sum - (K_W+1)'(NUM_TAPS));
  end

  assign rd_data = mem[rd_ch][rd_idx];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr[c] <= '0;
        for (int t = 0; t < NUM_TAPS; t++) mem[c][t] <= '0;
      end
    end else if (we) begin
      mem[wr_ch][wr_ptr[wr_ch]] <= wr_data;
      wr_ptr[wr_ch] <= (wr_ptr[wr_ch] == K_W'(NUM_TAPS - 1)) ? '0 : wr_ptr[wr_ch] + 1'b1;
    end
  end

endmodule

// File: rtl/fir_mc.sv
// Time-multiplexed multi-channel FIR with one shared MAC and valid/ready handshakes.
// FIR_SAT_EN: when defined, narrowing rounds half-up and saturates; otherwise floor-shift and wrap.
//
// state | meaning
// IDLE  | in_ready high, coefficient writes accepted, waiting for a sample
// MAC   | one tap per cycle, k = 0..NUM_TAPS-1, newest sample paired with h[0]
// OUT   | result held on y/out_ch with out_valid high until the sink takes it
module fir_mc
  import fir_pkg::*;
#(
  parameter int NUM_TAPS = 10,
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 16,
  parameter int NUM_CH   = 2,
  parameter int OUT_W    = 18,
  parameter int SHIFT    = 0,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int K_W     = $clog2(NUM_TAPS)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CH_W-1:0]          in_ch,
  input  logic signed [DATA_W-1:0] xin,
  input  logic                     coef_we,
  input  logic [K_W-1:0]           coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     coef_err,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH_W-1:0]          out_ch,
  output logic signed [OUT_W-1:0]  y
);

  localparam int ACC_W  = acc_w(DATA_W, COEF_W, NUM_TAPS);
  localparam int PROD_W = DATA_W + COEF_W;

  state_t                   state_q;
  logic [K_W-1:0]           k_q;
  logic [CH_W-1:0]          ch_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [COEF_W-1:0] h [NUM_TAPS];

  logic signed [DATA_W-1:0] x_rd;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [OUT_W-1:0]  y_next;
  logic                     ch_ok;
  logic                     addr_ok;
  logic                     accept;

  assign ch_ok   = 32'(in_ch) < NUM_CH;
  assign addr_ok = 32'(coef_addr) < NUM_TAPS;
  assign accept  = (state_q == IDLE) && in_valid && in_ready && ch_ok;

  fir_delay_line #(
    .NUM_TAPS(NUM_TAPS),
    .DATA_W  (DATA_W),
    .NUM_CH  (NUM_CH)
  ) u_delay_line (
    .clock  (clock),
    .reset_n(reset_n),
    .we     (accept),
    .wr_ch  (in_ch),
    .wr_data(xin),
    .rd_ch  (ch_q),
    .rd_k   (k_q),
    .rd_data(x_rd)
  );

  always_comb begin
    prod     = x_rd * h[k_q];
    acc_next = acc_q + ACC_W'(prod);
`ifdef FIR_SAT_EN
    y_next   = OUT_W'(round_sat(64'(acc_next), SHIFT, OUT_W));
`else
    y_next   = OUT_W'(acc_next >>> SHIFT);
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      k_q       <= '0;
      ch_q      <= '0;
      acc_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      coef_err  <= 1'b0;
      out_ch    <= '0;
      y         <= '0;
      for (int t = 0; t < NUM_TAPS; t++) h[t] <= '0;
    end else begin
      coef_err <= 1'b0;
      case (state_q)
        IDLE: begin
          // Write lands before the pass starts, so a same-cycle accept sees the new tap.
          if (coef_we && addr_ok) h[coef_addr] <= coef_data;
          if (accept) begin
            ch_q     <= in_ch;
            acc_q    <= '0;
            k_q      <= '0;
            in_ready <= 1'b0;
            state_q  <= MAC;
          end
        end
        MAC: begin
          coef_err <= coef_we;
          acc_q    <= acc_next;
          k_q      <= k_q + 1'b1;
          if (k_q == K_W'(NUM_TAPS - 1)) begin
            y         <= y_next;
            out_ch    <= ch_q;
            out_valid <= 1'b1;
            state_q   <= OUT;
          end
        end
        OUT: begin
          coef_err <= coef_we;
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mc.sv
// Scoreboard bench for fir_mc (4 taps, 2 channels, 16-bit out): stimulus pushes
// hand-computed results, a monitor pops and compares on each output handshake.
module tb_fir_mc;

  logic               clock = 1'b0;
  logic               reset_n;
  logic               in_valid;
  logic               in_ready;
  logic [0:0]         in_ch;
  logic signed [15:0] xin;
  logic               coef_we;
  logic [1:0]         coef_addr;
  logic signed [15:0] coef_data;
  logic               coef_err;
  logic               out_valid;
  logic               out_ready;
  logic [0:0]         out_ch;
  logic signed [15:0] y;

  typedef struct {
    logic               ch;
    logic signed [15:0] y;
    int                 cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  fir_mc #(
    .NUM_TAPS(4), .DATA_W(16), .COEF_W(16), .NUM_CH(2), .OUT_W(16), .SHIFT(0)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ch    (in_ch),
    .xin      (xin),
    .coef_we  (coef_we),
    .coef_addr(coef_addr),
    .coef_data(coef_data),
    .coef_err (coef_err),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ch   (out_ch),
    .y        (y)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", in_ready, 1);
  endtask

  task automatic send(input logic ch, input logic signed [15:0] x,
                      input bit expect_out, input logic signed [15:0] exp_y);
    exp_t e;
    wait_idle();
    in_valid = 1'b1;
    in_ch    = ch;
    xin      = x;
    if (expect_out) begin
      e.ch = ch; e.y = exp_y; e.cyc = cyc;
      sb.push_back(e);
    end
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic load_coef(input logic [1:0] addr, input logic signed [15:0] data);
    wait_idle();
    coef_we   = 1'b1;
    coef_addr = addr;
    coef_data = data;
    @(negedge clock);
    coef_we = 1'b0;
  endtask

  // Monitor: latency on each rising out_valid, payload on each handshake.
  initial begin
    bit   prev_valid;
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clock);
      #1;
      if (!reset_n) begin
        prev_valid = 1'b0;
      end else begin
        if (out_valid && !prev_valid) begin
          if (sb.size() == 0) check("unexpected_out_valid", out_valid, 0);
          else check("latency", cyc - sb[0].cyc, 5);
        end
        if (out_valid && out_ready && sb.size() > 0) begin
          e = sb.pop_front();
          check("out_ch", out_ch, e.ch);
          check("y", y, e.y);
        end
        prev_valid = out_valid;
      end
    end
  end

  initial begin
    exp_t e;
    int   n;
    reset_n = 1'b0; in_valid = 1'b0; in_ch = '0; xin = '0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0; out_ready = 1'b1;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_coef_err", coef_err, 0);
    check("rst_y", y, 0);
    check("rst_out_ch", out_ch, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // 1: impulse response on ch0
    for (int k = 0; k < 4; k++) load_coef(2'(k), 16'(k + 1));
    send(0, 1, 1, 1);
    send(0, 0, 1, 2);
    send(0, 0, 1, 3);
    send(0, 0, 1, 4);
    send(0, 0, 1, 0);

    // 2: channel isolation
    send(0, 100, 1, 100);
    send(1, 1,   1, 1);
    send(0, 100, 1, 300);
    send(1, 0,   1, 2);
    send(0, 100, 1, 600);
    send(1, 0,   1, 3);
    send(0, 100, 1, 1000);
    send(1, 0,   1, 4);

    // 3: backpressure; ch0 history 100,100,100 plus new 5 -> 5+200+300+400
    wait_idle();
    out_ready = 1'b0;
    send(0, 5, 1, 905);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_y", y, 905);
      check("bp_out_ch", out_ch, 0);
      check("bp_in_ready", in_ready, 0);
      @(negedge clock);
    end
    out_ready = 1'b1;
    @(negedge clock);
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);

    // 4: overflow on ch1 (history 1,0,0,0 -> newest-4 become 0,0,0,32767 ...)
    for (int k = 0; k < 4; k++) load_coef(2'(k), 16'sd32767);
`ifdef FIR_SAT_EN
    for (int k = 1; k <= 4; k++) send(1, 16'sd32767, 1, 16'sd32767);
`else
    for (int k = 1; k <= 4; k++) send(1, 16'sd32767, 1, 16'(k));
`endif

    // 5: reset during the second MAC cycle
    send(0, 1, 0, 0);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check("post_rst_out_valid", out_valid, 0);
    end
    check("post_rst_in_ready", in_ready, 1);
    send(0, 1, 1, 0);

    // 6: coefficient write while busy is dropped and flagged for one cycle
    for (int k = 0; k < 4; k++) load_coef(2'(k), 16'(k + 1));
    send(1, 7, 1, 7);
    coef_we = 1'b1; coef_addr = 2'd0; coef_data = 16'sd9;
    @(negedge clock);
    coef_we = 1'b0;
    check("coef_err_pulse", coef_err, 1);
    @(negedge clock);
    check("coef_err_clear", coef_err, 0);
    send(1, 1, 1, 15);

    // Same-cycle write and accept: the pass uses the new h[0]=5 -> 5*2+1*2+7*3
    wait_idle();
    coef_we = 1'b1; coef_addr = 2'd0; coef_data = 16'sd5;
    in_valid = 1'b1; in_ch = 1'b1; xin = 16'sd2;
    e.ch = 1'b1; e.y = 16'sd33; e.cyc = cyc;
    sb.push_back(e);
    @(negedge clock);
    coef_we = 1'b0; in_valid = 1'b0;

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("scoreboard_drained", sb.size(), 0);
    @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
